// File: rtl/wb_initiator_if.sv
// Command, response and Wishbone master signal bundle
// for the single-outstanding Wishbone initiator.
interface wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr,
    input  cmd_dat, cmd_sel, rsp_ready,
    input  wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid,
    output rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr,
    output cmd_dat, cmd_sel, rsp_ready,
    output wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid,
    input  rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_initiator.sv
// Wishbone initiator: one transaction in flight,
// bus timeout, response hold and txn/err counters.
module wb_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_initiator_if.master bus,
  output logic [15:0]   txn_count,
  output logic [7:0]    err_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rv_q, rv_d;
  logic [31:0] rdat_q, rdat_d;
  logic        rerr_q, rerr_d;
  logic [15:0] txn_q, txn_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rv_d    = rv_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    txn_d   = txn_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && rdy_q) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          cyc_d   = 1'b1;
          tmo_d   = 8'd0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack beats a timeout landing on the same cycle
        if (bus.wbm_ack_i) begin
          rdat_d  = we_q ? 32'd0 : bus.wbm_dat_i;
          rerr_d  = 1'b0;
          cyc_d   = 1'b0;
          rv_d    = 1'b1;
          txn_d   = txn_q + 16'd1;
          state_d = RSP;
        end else if (tmo_q == TMO_LAST) begin
          rdat_d  = 32'd0;
          rerr_d  = 1'b1;
          cyc_d   = 1'b0;
          rv_d    = 1'b1;
          txn_d   = txn_q + 16'd1;
          if (err_q != 8'hFF)
            err_d = err_q + 8'd1;
          state_d = RSP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      rv_q    <= 1'b0;
      rdat_q  <= 32'd0;
      rerr_q  <= 1'b0;
      txn_q   <= 16'd0;
      err_q   <= 8'd0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_dat   = rdat_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign txn_count     = txn_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: write, read,
// timeout, backpressure, back-to-back, reset, saturation.
module tb_wb_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] txn_count;
  logic [7:0]  err_count;
  int          vectors = 0;
  int          miscompares = 0;

  wb_initiator_if bus ();

  wb_initiator #(.TIMEOUT(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Counts BUS cycles until cyc drops; ack_at = 0 means never ack.
  task automatic run_bus(input int ack_at, input logic [31:0] d,
                         output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.wbm_cyc_o !== 1'b1) break;
      n++;
      if (i == ack_at) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = d;
      end
      tick();
      bus.wbm_ack_i = 1'b0;
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_cyc_stb got %b%b exp 00", bus.wbm_cyc_o, bus.wbm_stb_o);
    end
    vectors++;
    if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rdy_rv got %b%b exp 00", bus.cmd_ready, bus.rsp_valid);
    end
    vectors++;
    if (txn_count !== 16'd0 || err_count !== 8'd0 || bus.wbm_adr_o !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_regs got txn=%0h err=%0h adr=%0h exp 0", txn_count, err_count, bus.wbm_adr_o);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_rdy got %b exp 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF);
    vectors++;
    if (bus.cmd_ready !== 1'b0 || bus.wbm_we_o !== 1'b1 || bus.wbm_sel_o !== 4'hF) begin
      miscompares++;
      $display("FAIL wr_fields got rdy=%b we=%b sel=%h exp 0 1 f", bus.cmd_ready, bus.wbm_we_o, bus.wbm_sel_o);
    end
    for (int i = 1; i <= 3; i++) begin
      vectors++;
      if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 ||
          bus.wbm_adr_o !== 32'h3000_0004 || bus.wbm_dat_o !== 32'hA5A5_0001) begin
        miscompares++;
        $display("FAIL wr_bus_hold c%0d got cyc=%b stb=%b adr=%h dat=%h exp 1 1 30000004 a5a50001",
                 i, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o);
      end
      if (i == 3) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
      end
      tick();
      bus.wbm_ack_i = 1'b0;
    end
    vectors++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_dat !== 32'd0 || txn_count !== 16'd1) begin
      miscompares++;
      $display("FAIL wr_rsp got cyc=%b rv=%b err=%b dat=%h txn=%0d exp 0 1 0 0 1",
               bus.wbm_cyc_o, bus.rsp_valid, bus.rsp_err, bus.rsp_dat, txn_count);
    end
    release_rsp();
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_release got rv=%b rdy=%b exp 0 1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_read();
    int n;
    issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    run_bus(1, 32'h1234_5678, n);
    vectors++;
    if (n !== 1 || bus.rsp_dat !== 32'h1234_5678 || bus.rsp_err !== 1'b0 || txn_count !== 16'd2) begin
      miscompares++;
      $display("FAIL rd got n=%0d dat=%h err=%b txn=%0d exp 1 12345678 0 2",
               n, bus.rsp_dat, bus.rsp_err, txn_count);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'h3);
    run_bus(0, 32'h0, n);
    vectors++;
    if (n !== 16 || bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_dat !== 32'd0 ||
        err_count !== 8'd1 || txn_count !== 16'd3) begin
      miscompares++;
      $display("FAIL tmo got n=%0d rv=%b err=%b dat=%h ec=%0d txn=%0d exp 16 1 1 0 1 3",
               n, bus.rsp_valid, bus.rsp_err, bus.rsp_dat, err_count, txn_count);
    end
    release_rsp();
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    run_bus(16, 32'h0BAD_F00D, n);
    vectors++;
    if (n !== 16 || bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'h0BAD_F00D ||
        err_count !== 8'd1 || txn_count !== 16'd4) begin
      miscompares++;
      $display("FAIL tmo_ack_wins got n=%0d err=%b dat=%h ec=%0d txn=%0d exp 16 0 0badf00d 1 4",
               n, bus.rsp_err, bus.rsp_dat, err_count, txn_count);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int n;
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    run_bus(1, 32'hCAFE_0001, n);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hCAFE_0001 ||
          bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold c%0d got rv=%b dat=%h err=%b rdy=%b exp 1 cafe0001 0 0",
                 i, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.cmd_ready);
      end
      if (i == 1) begin
        bus.cmd_we    = 1'b1;
        bus.cmd_adr   = 32'h4000_0000;
        bus.cmd_valid = 1'b1;
      end
      if (i == 2) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hFFFF_FFFF;
      end
      tick();
      bus.cmd_valid = 1'b0;
      bus.wbm_ack_i = 1'b0;
    end
    release_rsp();
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0 ||
        bus.wbm_adr_o !== 32'h3000_0010) begin
      miscompares++;
      $display("FAIL bp_release got rv=%b rdy=%b cyc=%b adr=%h exp 0 1 0 30000010",
               bus.rsp_valid, bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_adr_o);
    end
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    vectors++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.rsp_valid !== 1'b0 || txn_count !== 16'd5) begin
      miscompares++;
      $display("FAIL idle_ack got cyc=%b rv=%b txn=%0d exp 0 0 5", bus.wbm_cyc_o, bus.rsp_valid, txn_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1;
    issue(1'b1, 32'h3000_0020, 32'h1111_1111, 4'h1);
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rsp got rv=%b rdy=%b exp 1 0", bus.rsp_valid, bus.cmd_ready);
    end
    tick();
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_rdy got %b exp 1", bus.cmd_ready);
    end
    issue(1'b0, 32'h3000_0024, 32'h0, 4'h2);
    vectors++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0024 || bus.wbm_sel_o !== 4'h2) begin
      miscompares++;
      $display("FAIL b2b_second got cyc=%b adr=%h sel=%h exp 1 30000024 2",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.wbm_sel_o);
    end
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h2222_2222;
    tick();
    bus.wbm_ack_i = 1'b0;
    tick();
    bus.rsp_ready = 1'b0;
    vectors++;
    if (txn_count !== 16'd7 || bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_txn got txn=%0d rdy=%b exp 7 1", txn_count, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_in_bus();
    logic seen;
    issue(1'b1, 32'h3000_0030, 32'h3333_3333, 4'hF);
    tick();
    vectors++;
    if (bus.wbm_cyc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rib_cyc2 got %b exp 1", bus.wbm_cyc_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.cmd_ready !== 1'b0 || txn_count !== 16'd0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL rib_edge got cyc=%b stb=%b rv=%b rdy=%b txn=%0d ec=%0d exp 0 0 0 0 0 0",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid, bus.cmd_ready, txn_count, err_count);
    end
    tick();
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rib_rdy got %b exp 1", bus.cmd_ready);
    end
    seen = 1'b0;
    bus.wbm_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0) seen = 1'b1;
    end
    bus.wbm_ack_i = 1'b0;
    vectors++;
    if (seen !== 1'b0 || txn_count !== 16'd0) begin
      miscompares++;
      $display("FAIL rib_quiet got seen=%b txn=%0d exp 0 0", seen, txn_count);
    end
  endtask

  task automatic test_saturation();
    int n;
    bus.rsp_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      issue(1'b0, 32'h5000_0000, 32'h0, 4'hF);
      run_bus(0, 32'h0, n);
      if (k == 254 || k == 255 || k == 256) begin
        vectors++;
        if (err_count !== ((k == 254) ? 8'hFE : 8'hFF) || txn_count !== 16'(k)) begin
          miscompares++;
          $display("FAIL sat_k%0d got ec=%h txn=%0d exp %h %0d",
                   k, err_count, txn_count, (k == 254) ? 8'hFE : 8'hFF, k);
        end
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    vectors++;
    if (err_count !== 8'hFF || txn_count !== 16'd300) begin
      miscompares++;
      $display("FAIL sat_final got ec=%h txn=%0d exp ff 300", err_count, txn_count);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'd0;
    bus.cmd_dat   = 32'd0;
    bus.cmd_sel   = 4'd0;
    bus.rsp_ready = 1'b0;
    bus.wbm_dat_i = 32'd0;
    bus.wbm_ack_i = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_in_bus();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
